// File: rtl/vram_arb_pkg.sv
// Shared definitions for the VRAM arbiter: pipeline owner tags and the default loader
// promotion threshold.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_LDR  = 2'd3
    } owner_e;

    localparam int LDR_MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/vram_arb_prio.sv
// Combinational grant selection: video first, then a starved loader, then CPU, then loader.
module vram_arb_prio
    import vram_arb_pkg::*;
(
    input  logic   vid_req_i,
    input  logic   cpu_req_i,
    input  logic   ldr_req_i,
    input  logic   cpu_busy_i,
    input  logic   ldr_busy_i,
    input  logic   ldr_promoted_i,
    output owner_e grant_o
);

    logic cpu_ok;
    logic ldr_ok;

    assign cpu_ok = cpu_req_i && !cpu_busy_i;
    assign ldr_ok = ldr_req_i && !ldr_busy_i;

    always_comb begin
        // NOTE: default first so every path assigns grant_o and no latch is inferred.
        grant_o = OWN_NONE;
        if (vid_req_i) begin
            grant_o = OWN_VID;
        end else if (ldr_ok && ldr_promoted_i) begin
            grant_o = OWN_LDR;
        end else if (cpu_ok) begin
            grant_o = OWN_CPU;
        end else if (ldr_ok) begin
            grant_o = OWN_LDR;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Three-requester arbiter for a single-port synchronous VRAM: one access per cycle,
// fixed 3-cycle grant-to-ack latency, acks routed by the owner tag carried down the pipe.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int LDR_MAX_WAIT = LDR_MAX_WAIT_DEFAULT,
    parameter int AW           = 15
) (
    input  logic          clk_sys,
    input  logic          reset,

    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    output logic [7:0]    vid_data,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic          cpu_ack,
    output logic [7:0]    cpu_dout,

    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [7:0]    ldr_din,
    output logic          ldr_ack,
    output logic [7:0]    ldr_dout,

    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_din,
    input  logic [7:0]    ram_dout
);

    localparam int            CW       = (LDR_MAX_WAIT < 1) ? 1 : $clog2(LDR_MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_SAT = CW'(LDR_MAX_WAIT);

    owner_e        grant;
    logic          grant_we;
    logic [AW-1:0] grant_addr;
    logic [7:0]    grant_din;
    logic          ldr_promoted;

    logic [AW-1:0] ram_addr_q,  ram_addr_d;
    logic          ram_we_q,    ram_we_d;
    logic [7:0]    ram_din_q,   ram_din_d;
    owner_e        s1_own_q,    s1_own_d;
    owner_e        s2_own_q,    s2_own_d;
    logic          vid_valid_q, vid_valid_d;
    logic          cpu_ack_q,   cpu_ack_d;
    logic          ldr_ack_q,   ldr_ack_d;
    logic [7:0]    vid_data_q,  vid_data_d;
    logic [7:0]    cpu_dout_q,  cpu_dout_d;
    logic [7:0]    ldr_dout_q,  ldr_dout_d;
    logic          cpu_busy_q,  cpu_busy_d;
    logic          ldr_busy_q,  ldr_busy_d;
    logic [CW-1:0] wait_cnt_q,  wait_cnt_d;

    assign ldr_promoted = (wait_cnt_q == WAIT_SAT);

    vram_arb_prio u_prio (
        .vid_req_i      (vid_req),
        .cpu_req_i      (cpu_req),
        .ldr_req_i      (ldr_req),
        .cpu_busy_i     (cpu_busy_q),
        .ldr_busy_i     (ldr_busy_q),
        .ldr_promoted_i (ldr_promoted),
        .grant_o        (grant)
    );

    // Capture the winner's request fields; video is always a read.
    always_comb begin
        grant_we   = 1'b0;
        grant_addr = vid_addr;
        grant_din  = '0;
        case (grant)
            OWN_CPU: begin
                grant_we   = cpu_we;
                grant_addr = cpu_addr;
                grant_din  = cpu_din;
            end
            OWN_LDR: begin
                grant_we   = ldr_we;
                grant_addr = ldr_addr;
                grant_din  = ldr_din;
            end
            default: ;
        endcase
    end

    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        if (grant != OWN_NONE) begin
            ram_addr_d = grant_addr;
            ram_din_d  = grant_din;
        end
        ram_we_d = grant_we;

        s1_own_d = grant;
        s2_own_d = s1_own_q;

        // Stage 2 owner sees this cycle's ram_dout; its ack goes out next cycle.
        vid_valid_d = (s2_own_q == OWN_VID);
        cpu_ack_d   = (s2_own_q == OWN_CPU);
        ldr_ack_d   = (s2_own_q == OWN_LDR);
        vid_data_d  = vid_valid_d ? ram_dout : vid_data_q;
        cpu_dout_d  = cpu_ack_d   ? ram_dout : cpu_dout_q;
        ldr_dout_d  = ldr_ack_d   ? ram_dout : ldr_dout_q;

        cpu_busy_d = cpu_busy_q;
        if (grant == OWN_CPU) begin
            cpu_busy_d = 1'b1;
        end else if (cpu_ack_q) begin
            cpu_busy_d = 1'b0;
        end

        ldr_busy_d = ldr_busy_q;
        if (grant == OWN_LDR) begin
            ldr_busy_d = 1'b1;
        end else if (ldr_ack_q) begin
            ldr_busy_d = 1'b0;
        end

        wait_cnt_d = wait_cnt_q;
        if (grant == OWN_LDR) begin
            wait_cnt_d = '0;
        end else if (ldr_req && !ldr_busy_q && !ldr_promoted) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_din_q   <= '0;
            s1_own_q    <= OWN_NONE;
            s2_own_q    <= OWN_NONE;
            vid_valid_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            vid_data_q  <= '0;
            cpu_dout_q  <= '0;
            ldr_dout_q  <= '0;
            cpu_busy_q  <= 1'b0;
            ldr_busy_q  <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_din_q   <= ram_din_d;
            s1_own_q    <= s1_own_d;
            s2_own_q    <= s2_own_d;
            vid_valid_q <= vid_valid_d;
            cpu_ack_q   <= cpu_ack_d;
            ldr_ack_q   <= ldr_ack_d;
            vid_data_q  <= vid_data_d;
            cpu_dout_q  <= cpu_dout_d;
            ldr_dout_q  <= ldr_dout_d;
            cpu_busy_q  <= cpu_busy_d;
            ldr_busy_q  <= ldr_busy_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_din   = ram_din_q;
    assign vid_valid = vid_valid_q;
    assign vid_data  = vid_data_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_dout  = cpu_dout_q;
    assign ldr_ack   = ldr_ack_q;
    assign ldr_dout  = ldr_dout_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural RAM, grant-history reference model, directed
// vector table, hand-written corner sequences and a randomized phase.
module tb_vram_arbiter;

    localparam int AW   = 15;
    localparam int MAXW = 15;
    localparam int NC   = 4096;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          vid_req,  cpu_req,  ldr_req;
    logic          cpu_we,   ldr_we;
    logic [AW-1:0] vid_addr, cpu_addr, ldr_addr;
    logic [7:0]    cpu_din,  ldr_din;
    logic          vid_valid, cpu_ack, ldr_ack;
    logic [7:0]    vid_data,  cpu_dout, ldr_dout;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout;

    vram_arbiter #(.LDR_MAX_WAIT(MAXW), .AW(AW)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_valid (vid_valid),
        .vid_data  (vid_data),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_ack   (cpu_ack),
        .cpu_dout  (cpu_dout),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_din   (ldr_din),
        .ldr_ack   (ldr_ack),
        .ldr_dout  (ldr_dout),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk_sys = ~clk_sys;

    // Single-port synchronous RAM, read-before-write.
    logic [7:0] ram_mem [0:(1<<AW)-1];
    always @(posedge clk_sys) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    int tests = 0;
    int fails = 0;
    int k     = 0;

    // Reference model: memory contents in grant order plus per-observation expectations.
    logic [7:0]    mref [0:(1<<AW)-1];
    int            cpu_last = -100;
    int            ldr_last = -100;
    int            m_wait   = 0;
    logic [AW-1:0] m_addr_hold = '0;
    bit            ev_v  [3][NC];
    bit            ev_we [3][NC];
    logic [7:0]    ev_d  [3][NC];
    bit            iss_we   [NC];
    logic [AW-1:0] iss_addr [NC];
    logic [7:0]    iss_din  [NC];
    bit            rst_at   [NC];
    bit            hk [3];
    logic [7:0]    hv [3];
    string         nm [3] = '{"vid", "cpu", "ldr"};

    typedef struct {
        int            who;
        bit            we;
        logic [AW-1:0] addr;
        logic [7:0]    din;
        logic [7:0]    exp;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @obs %0d: got 0x%0h, want 0x%0h", name, k, act, exp);
        end
    endtask

    task automatic model_drive();
        int who;
        logic [AW-1:0] a;
        logic w;
        logic [7:0] d;
        bit ce, le, pr;
        if (reset) begin
            for (int j = k; j < k + 4; j++)
                for (int r = 0; r < 3; r++) ev_v[r][j] = 1'b0;
            cpu_last = -100; ldr_last = -100; m_wait = 0; m_addr_hold = '0;
            iss_we[k] = 1'b0; iss_addr[k] = '0; iss_din[k] = '0; rst_at[k] = 1'b1;
            return;
        end
        ce = cpu_req && ((k - cpu_last) > 3);
        le = ldr_req && ((k - ldr_last) > 3);
        pr = (m_wait == MAXW);
        who = -1;
        if (vid_req)         who = 0;
        else if (le && pr)   who = 2;
        else if (ce)         who = 1;
        else if (le)         who = 2;
        if (who == 2)                 m_wait = 0;
        else if (le && m_wait < MAXW) m_wait++;
        if (who < 0) begin
            iss_we[k] = 1'b0; iss_addr[k] = m_addr_hold;
            return;
        end
        case (who)
            0:       begin a = vid_addr; w = 1'b0;   d = '0;      end
            1:       begin a = cpu_addr; w = cpu_we; d = cpu_din; cpu_last = k; end
            default: begin a = ldr_addr; w = ldr_we; d = ldr_din; ldr_last = k; end
        endcase
        if (w) mref[a] = d;
        ev_v[who][k+2] = 1'b1; ev_we[who][k+2] = w; ev_d[who][k+2] = mref[a];
        iss_we[k] = w; iss_addr[k] = a; iss_din[k] = d; m_addr_hold = a;
    endtask

    task automatic check_obs(input int j);
        logic       av [3];
        logic [7:0] dv [3];
        av[0] = vid_valid; av[1] = cpu_ack;  av[2] = ldr_ack;
        dv[0] = vid_data;  dv[1] = cpu_dout; dv[2] = ldr_dout;
        for (int r = 0; r < 3; r++) begin
            check({nm[r], "_ack"}, av[r], ev_v[r][j]);
            if (rst_at[j]) begin
                hk[r] = 1'b1; hv[r] = '0;
            end else if (ev_v[r][j]) begin
                hk[r] = !ev_we[r][j]; hv[r] = ev_d[r][j];
            end
            if (hk[r]) check({nm[r], "_data"}, dv[r], hv[r]);
        end
        check("ram_we", ram_we, iss_we[j]);
        check("ram_addr", ram_addr, iss_addr[j]);
        if (iss_we[j]) check("ram_din", ram_din, iss_din[j]);
    endtask

    task automatic tick();
        if (k >= NC - 8) begin
            $display("FAIL cycle_budget: obs %0d, limit %0d", k, NC - 8);
            $fatal(1, "cycle budget exhausted");
        end
        model_drive();
        @(negedge clk_sys);
        check_obs(k);
        k++;
    endtask

    task automatic do_access(input int who, input bit we, input logic [AW-1:0] a,
                             input logic [7:0] d, output int lat, output logic [7:0] dout);
        lat = -1; dout = '0;
        case (who)
            0:       begin vid_req = 1'b1; vid_addr = a; end
            1:       begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d; end
            default: begin ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_din = d; end
        endcase
        for (int t = 1; t <= 12; t++) begin
            tick();
            vid_req = 1'b0;
            if (who == 0 && vid_valid) begin lat = t; dout = vid_data; break; end
            if (who == 1 && cpu_ack)   begin lat = t; dout = cpu_dout; break; end
            if (who == 2 && ldr_ack)   begin lat = t; dout = ldr_dout; break; end
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nv, ncpu, cpu_t, nack;
        logic [7:0] dout;

        vecs[0] = '{1, 1'b1, 15'h4000, 8'hA5, 8'h00};
        vecs[1] = '{1, 1'b0, 15'h4000, 8'h00, 8'hA5};
        vecs[2] = '{2, 1'b1, 15'h2222, 8'hC3, 8'h00};
        vecs[3] = '{2, 1'b0, 15'h4000, 8'h00, 8'hA5};
        vecs[4] = '{0, 1'b0, 15'h2222, 8'h00, 8'hC3};
        vecs[5] = '{1, 1'b1, 15'h7FFF, 8'h5A, 8'h00};
        vecs[6] = '{0, 1'b0, 15'h7FFF, 8'h00, 8'h5A};
        vecs[7] = '{1, 1'b0, 15'h0000, 8'h00, 8'h00};

        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = '0;
            mref[i]    = '0;
        end
        reset = 1'b1;
        vid_req = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0;
        cpu_we = 1'b0; ldr_we = 1'b0;
        vid_addr = '0; cpu_addr = '0; ldr_addr = '0; cpu_din = '0; ldr_din = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Directed single accesses: fixed latency and read-after-write data.
        for (int i = 0; i < 8; i++) begin
            do_access(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].din, lat, dout);
            check($sformatf("vec%0d_latency", i), lat, 3);
            if (!vecs[i].we) check($sformatf("vec%0d_data", i), dout, vecs[i].exp);
        end

        // Loader write then video read of the same address on the next cycle.
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 15'h1800; ldr_din = 8'h3C;
        tick();
        vid_req = 1'b1; vid_addr = 15'h1800;
        tick();
        vid_req = 1'b0;
        tick();
        check("raw_ldr_ack", ldr_ack, 1);
        ldr_req = 1'b0;
        tick();
        check("raw_vid_valid", vid_valid, 1);
        check("raw_vid_data", vid_data, 8'h3C);
        tick();

        // All three request together: vid, cpu, ldr acks on consecutive cycles.
        vid_req = 1'b1; vid_addr = 15'h4000;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h2222;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 15'h7FFF;
        tick();
        vid_req = 1'b0;
        tick();
        tick();
        check("sim_vid_ack", vid_valid, 1);
        check("sim_vid_cpu_quiet", cpu_ack, 0);
        tick();
        check("sim_cpu_ack", cpu_ack, 1);
        check("sim_cpu_data", cpu_dout, 8'hC3);
        cpu_req = 1'b0;
        tick();
        check("sim_ldr_ack", ldr_ack, 1);
        check("sim_ldr_data", ldr_dout, 8'h5A);
        ldr_req = 1'b0;
        repeat (2) tick();

        // Preload distinct bytes, then stream 16 video fetches with the CPU waiting.
        for (int i = 0; i < 16; i++) begin
            do_access(1, 1'b1, 15'h0100 + AW'(i), 8'h10 + 8'(i), lat, dout);
        end
        nv = 0; ncpu = 0; cpu_t = -1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0100;
        for (int i = 0; i < 16; i++) begin
            vid_req = 1'b1; vid_addr = 15'h0100 + AW'(i);
            tick();
            if (vid_valid) begin check("stream_order", vid_data, 32'h10 + nv); nv++; end
            if (cpu_ack) ncpu++;
        end
        vid_req = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (vid_valid) begin check("stream_order", vid_data, 32'h10 + nv); nv++; end
            if (cpu_ack && cpu_t < 0) begin cpu_t = t; cpu_req = 1'b0; end
        end
        check("stream_vid_count", nv, 16);
        check("stream_cpu_early", ncpu, 0);
        check("stream_cpu_ack_tick", cpu_t, 3);
        check("stream_cpu_data", cpu_dout, 8'h10);

        // Starve the loader behind video, then it must beat the CPU; after that CPU wins again.
        nack = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0101;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 15'h0102;
        for (int i = 0; i < 20; i++) begin
            vid_req = 1'b1; vid_addr = AW'(i);
            tick();
            if (cpu_ack || ldr_ack) nack++;
        end
        check("promo_no_ack_during_video", nack, 0);
        vid_req = 1'b0;
        repeat (3) tick();
        check("promo_ldr_first", ldr_ack, 1);
        check("promo_cpu_waits", cpu_ack, 0);
        check("promo_ldr_data", ldr_dout, 8'h12);
        ldr_req = 1'b0;
        tick();
        check("promo_cpu_next", cpu_ack, 1);
        cpu_req = 1'b0;
        repeat (3) tick();
        cpu_req = 1'b1; ldr_req = 1'b1;
        repeat (3) tick();
        check("nopromo_cpu_first", cpu_ack, 1);
        check("nopromo_ldr_waits", ldr_ack, 0);
        cpu_req = 1'b0;
        tick();
        check("nopromo_ldr_next", ldr_ack, 1);
        ldr_req = 1'b0;
        repeat (2) tick();

        // Reset with accesses in flight: nothing acked, then a fresh CPU read completes.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0300; cpu_din = 8'h77;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 15'h0200;
        tick();
        tick();
        reset = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0;
        vid_req = 1'b1; vid_addr = 15'h0300;
        tick();
        check("rst_ram_we", ram_we, 0);
        nack = int'(vid_valid) + int'(cpu_ack) + int'(ldr_ack);
        vid_req = 1'b0;
        tick();
        nack += int'(vid_valid) + int'(cpu_ack) + int'(ldr_ack);
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0300;
        repeat (2) begin
            tick();
            nack += int'(vid_valid) + int'(cpu_ack) + int'(ldr_ack);
        end
        check("rst_dropped_acks", nack, 0);
        tick();
        check("rst_fresh_cpu_ack", cpu_ack, 1);
        check("rst_fresh_cpu_data", cpu_dout, 8'h77);
        cpu_req = 1'b0;
        tick();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 2000; c++) begin
            reset    = ($urandom_range(0, 199) == 0);
            vid_req  = ($urandom_range(0, 2) == 0);
            vid_addr = AW'($urandom_range(0, 63));
            if (cpu_ack ? ($urandom_range(0, 1) == 1) : (!cpu_req && $urandom_range(0, 3) == 0)) begin
                cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = AW'($urandom_range(0, 63)); cpu_din = 8'($urandom);
            end else if (cpu_ack) begin
                cpu_req = 1'b0;
            end
            if (ldr_ack ? ($urandom_range(0, 1) == 1) : (!ldr_req && $urandom_range(0, 3) == 0)) begin
                ldr_req = 1'b1; ldr_we = 1'($urandom_range(0, 1));
                ldr_addr = AW'($urandom_range(0, 63)); ldr_din = 8'($urandom);
            end else if (ldr_ack) begin
                ldr_req = 1'b0;
            end
            tick();
        end
        reset = 1'b0; vid_req = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0;
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
